// File: rtl/pcie_rst_seq_pkg.sv
// pcie_rst_seq_pkg: shared state encodings and CSR layout for the PCIe slot reset sequencer
package pcie_rst_seq_pkg;
  typedef enum logic [1:0] {PRS_HOLD, PRS_WAIT, PRS_RELEASE, PRS_DONE} prs_state_e;
  localparam int CTRL_RESTART = 7;
  localparam int CTRL_BUSY = 6;
  localparam int CTRL_DONE = 5;
  localparam logic [4:0] DELAY_OFS = 5'd1;
  localparam int PRESCALE = 32;
endpackage

// File: rtl/pcie_rst_seq_timer.sv
// pcie_rst_seq_timer: counts units*32 ce ticks after load, then pulses expired for one cycle
module pcie_rst_seq_timer
  import pcie_rst_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] units,
  output logic       expired
);
  logic [4:0] pre;
  logic [7:0] cnt;
  logic       armed;
  assign expired = armed && cnt == 8'd0;
  // a tick on the load cycle or on the expiry cycle is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
      armed <= 1'b0;
    end else if (load) begin
      pre <= '0;
      cnt <= units;
      armed <= 1'b1;
    end else if (expired) begin
      armed <= 1'b0;
    end else if (armed && ce) begin
      pre <= pre + 5'd1;
      if (pre == 5'(PRESCALE - 1)) cnt <= cnt - 8'd1;
    end
  end
endmodule

// File: rtl/pcie_rst_seq.sv
// pcie_rst_seq: releases PCIe slot resets one at a time after power good, with CSR control
module pcie_rst_seq
  import pcie_rst_seq_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h1d,
  parameter int         NUM_RST   = 3,
  parameter logic [7:0] DFL_DELAY = 8'd20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               pwr_ok,
  input  logic [4:0]         csr_a,
  input  logic [7:0]         csr_di,
  input  logic               csr_we,
  output logic [7:0]         csr_do,
  output logic [NUM_RST-1:0] rst_out,
  output logic               seq_done
);
  prs_state_e         state, state_n;
  logic [2:0]         idx, idx_n;
  logic [NUM_RST-1:0] seq_hold, hold_n, sw_mask;
  logic [7:0]         delay, ctrl;
  logic               ctrl_sel, dly_sel, restart, load, expired, busy, unused;
  assign ctrl_sel = csr_a == BASE_ADDR;
  assign dly_sel = csr_a == BASE_ADDR + DELAY_OFS;
  assign restart = csr_we && ctrl_sel && csr_di[CTRL_RESTART];
  assign busy = state == PRS_WAIT || state == PRS_RELEASE;
  assign seq_done = state == PRS_DONE;
  assign rst_out = seq_hold | sw_mask;
  assign unused = ^csr_di[6:NUM_RST];
  pcie_rst_seq_timer u_timer (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .load(load),
    .units(delay),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRS_HOLD;
      idx <= '0;
      seq_hold <= '1;
      sw_mask <= '0;
      delay <= DFL_DELAY;
    end else begin
      state <= state_n;
      idx <= idx_n;
      seq_hold <= hold_n;
      if (csr_we && ctrl_sel) sw_mask <= csr_di[NUM_RST-1:0];
      if (csr_we && dly_sel) delay <= csr_di;
    end
  end
  // power loss beats restart, which beats normal progression
  always_comb begin
    state_n = state;
    idx_n = idx;
    hold_n = seq_hold;
    load = 1'b0;
    if (!pwr_ok) begin
      state_n = PRS_HOLD;
      idx_n = '0;
      hold_n = '1;
    end else if (restart || state == PRS_HOLD) begin
      state_n = PRS_WAIT;
      idx_n = '0;
      hold_n = '1;
      load = 1'b1;
    end else if (state == PRS_WAIT) begin
      state_n = expired ? PRS_RELEASE : PRS_WAIT;
    end else if (state == PRS_RELEASE) begin
      hold_n = seq_hold & ~(NUM_RST'(1) << idx);
      state_n = idx == 3'(NUM_RST - 1) ? PRS_DONE : PRS_WAIT;
      idx_n = idx == 3'(NUM_RST - 1) ? idx : idx + 3'd1;
      load = idx != 3'(NUM_RST - 1);
    end
  end
  always_comb begin
    ctrl = '0;
    ctrl[4:0] = 5'(sw_mask);
    ctrl[CTRL_BUSY] = busy;
    ctrl[CTRL_DONE] = seq_done;
    csr_do = ctrl_sel ? ctrl : dly_sel ? delay : 8'h00;
  end
endmodule

// File: tb/tb_pcie_rst_seq.sv
// tb_pcie_rst_seq: directed stimulus with a tick-count reference model checked every cycle
module tb_pcie_rst_seq;
  logic       clk = 0, rst = 1, ce = 0, ce_en = 0, pwr_ok = 0, csr_we = 0;
  logic [4:0] csr_a = 0;
  logic [7:0] csr_di = 0, csr_do;
  logic [2:0] rst_out;
  logic       seq_done;
  int tests = 0, fails = 0;

  pcie_rst_seq dut (
    .clk(clk), .rst(rst), .ce(ce), .pwr_ok(pwr_ok), .csr_a(csr_a), .csr_di(csr_di),
    .csr_we(csr_we), .csr_do(csr_do), .rst_out(rst_out), .seq_done(seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    ce = ce_en & ~ce;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: phase 0 hold, 1 counting ticks, 2 release due, 3 all released
  int         m_phase, m_left, m_ch;
  logic [2:0] m_hold, m_mask;
  logic [7:0] m_delay;
  bit         m_ok = 0;
  always @(posedge clk) begin
    logic wc, wd;
    wc = csr_we && csr_a == 5'h1d;
    wd = csr_we && csr_a == 5'h1e;
    if (rst) begin
      m_phase = 0; m_hold = 3'b111; m_mask = 0; m_delay = 20; m_ch = 0; m_left = 0; m_ok = 1;
    end else begin
      if (!pwr_ok) begin
        m_phase = 0; m_hold = 3'b111;
      end else if ((wc && csr_di[7]) || m_phase == 0) begin
        m_phase = 1; m_ch = 0; m_left = int'(m_delay) * 32; m_hold = 3'b111;
      end else if (m_phase == 1) begin
        if (m_left == 0) m_phase = 2;
        else if (ce) m_left--;
      end else if (m_phase == 2) begin
        m_hold[m_ch] = 1'b0;
        if (m_ch == 2) m_phase = 3;
        else begin
          m_ch++; m_left = int'(m_delay) * 32; m_phase = 1;
        end
      end
      if (wc) m_mask = csr_di[2:0];
      if (wd) m_delay = csr_di;
    end
  end

  always @(negedge clk) if (m_ok) begin
    logic [7:0] exp_rd;
    logic busy, done;
    busy = m_phase == 1 || m_phase == 2;
    done = m_phase == 3;
    exp_rd = csr_a == 5'h1d ? {1'b0, busy, done, 2'b00, m_mask} : csr_a == 5'h1e ? m_delay : 8'h00;
    chk("model_rst_out", 8'(rst_out), 8'(m_hold | m_mask));
    chk("model_seq_done", 8'(seq_done), 8'(done));
    chk("model_csr_do", csr_do, exp_rd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1;
    tick();
    csr_we = 0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(name, csr_do, exp);
  endtask

  task automatic wait_change(input string name, input logic [2:0] exp, input int gap_lo);
    logic [2:0] old;
    int nce;
    bit hit;
    old = rst_out; nce = 0; hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk);
      if (ce) nce++;
      #1;
      hit = rst_out !== old;
    end
    chk({name, "_val"}, 8'(rst_out), 8'(exp));
    tests++;
    if (!hit || nce < gap_lo || nce > gap_lo + 2) begin
      fails++;
      $display("FAIL %s_gap: got %0d ce ticks expected %0d..%0d", name, nce, gap_lo, gap_lo + 2);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!seq_done && n < 2000) begin
      tick();
      n++;
    end
    chk(name, 8'(seq_done), 8'd1);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    rst = 0;
    chk("reset_rst_out", 8'(rst_out), 8'h07);
    chk("reset_done", 8'(seq_done), 8'h00);
    rd("reset_ctrl", 5'h1d, 8'h00);
    rd("reset_delay", 5'h1e, 8'd20);
    wr(5'h1e, 8'd1);
    ce_en = 1;
    pwr_ok = 1;
    wait_change("t1_rel0", 3'b110, 32);
    wait_change("t1_rel1", 3'b100, 32);
    wait_change("t1_rel2", 3'b000, 32);
    chk("t1_done", 8'(seq_done), 8'h01);
    rd("t1_ctrl", 5'h1d, 8'h20);
    pwr_ok = 0;
    tick();
    pwr_ok = 1;
    wait_change("t3_rel0", 3'b110, 32);
    pwr_ok = 0;
    tick();
    chk("t3_abort_rst", 8'(rst_out), 8'h07);
    chk("t3_abort_done", 8'(seq_done), 8'h00);
    pwr_ok = 1;
    wait_change("t3_again0", 3'b110, 32);
    wait_done("t3_done");
    ce_en = 0;
    wr(5'h1e, 8'd0);
    pwr_ok = 0;
    tick();
    pwr_ok = 1;
    n = 0;
    while (!seq_done && n < 20) begin
      tick();
      n++;
    end
    chk("t2_latency_le7", 8'(n >= 1 && n <= 7), 8'h01);
    chk("t2_rst_out", 8'(rst_out), 8'h00);
    wr(5'h1d, 8'h80);
    chk("t4_restart_rst", 8'(rst_out), 8'h07);
    rd("t4_busy", 5'h1d, 8'h40);
    wait_done("t4_done");
    pwr_ok = 0;
    tick();
    wr(5'h1d, 8'h80);
    tick();
    chk("t4_nopwr_rst", 8'(rst_out), 8'h07);
    rd("t4_nopwr_ctrl", 5'h1d, 8'h00);
    pwr_ok = 1;
    wait_done("t5_pre_done");
    wr(5'h1e, 8'd5);
    wr(5'h1d, 8'h02);
    chk("t5_mask_rst", 8'(rst_out), 8'h02);
    rd("t5_ctrl", 5'h1d, 8'h22);
    rd("t5_delay", 5'h1e, 8'h05);
    rd("t5_unmapped", 5'h03, 8'h00);
    wr(5'h1d, 8'h00);
    wr(5'h1e, 8'd2);
    ce_en = 1;
    csr_a = 5'h1d; csr_di = 8'h80; csr_we = 1;
    tick();
    csr_we = 0;
    repeat (10) tick();
    wr(5'h1e, 8'd4);
    wait_change("t6_gap64", 3'b110, 64 - 6);
    wait_change("t6_gap128", 3'b100, 128);
    repeat (20) tick();
    csr_a = 5'h1d; csr_di = 8'h80; csr_we = 1; pwr_ok = 0;
    tick();
    csr_we = 0;
    chk("t6_hold_rst", 8'(rst_out), 8'h07);
    rd("t6_hold_ctrl", 5'h1d, 8'h00);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
